// File: rtl/ram_burst_reader.sv
// Burst read engine: issues one RAM read per beat under credit control and streams the
// returned words over AXI-Stream through a small FIFO, flagging the final beat with tlast.
module ram_burst_reader #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_W          = 16,
    parameter int FIFO_DEPTH     = 4,
    localparam int LSB           = $clog2(AXI_WIDTH) - 3,
    localparam int AW            = AXI_ADDR_WIDTH - LSB
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 ram_ren,
    output logic [AW-1:0]        ram_addr,
    input  logic [AXI_WIDTH-1:0] ram_data,
    output logic [AXI_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        start_q;
    logic [LEN_W:0]       len_q;
    logic [LEN_W:0]       issued_q;
    logic [LEN_W:0]       recv_q;
    logic                 inflight_q;
    logic [PW-1:0]        wr_q;
    logic [PW-1:0]        rd_q;
    logic [OW-1:0]        occ_q;
    logic [FIFO_DEPTH-1:0] last_q;
    logic [AXI_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic        ren;
    logic        push;
    logic        pop;
    logic [OW:0] used;

    // Credits count both stored words and the read still in flight, so a push always fits.
    assign used = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
    assign ren  = (state_q == READ) && (used < DEPTH_C) && (issued_q <= len_q);
    assign push = inflight_q;
    assign pop  = (occ_q != '0) && m_axis_tready;

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign ram_ren       = ren;
    assign ram_addr      = start_q + AW'(issued_q);
    assign m_axis_tvalid = (occ_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? data_mem[rd_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_q[rd_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            start_q    <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            recv_q     <= '0;
            inflight_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            occ_q      <= '0;
            last_q     <= '0;
        end else begin
            inflight_q <= ren;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q  <= READ;
                        start_q  <= cmd_addr;
                        len_q    <= {1'b0, cmd_len};
                        issued_q <= '0;
                        recv_q   <= '0;
                    end
                end
                READ: begin
                    if (ren) begin
                        issued_q <= issued_q + (LEN_W + 1)'(1);
                        if (issued_q == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight_q && (occ_q == '0)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (push) begin
                last_q[wr_q] <= (recv_q == len_q);
                wr_q         <= (wr_q == LAST_IDX) ? '0 : wr_q + PW'(1);
                recv_q       <= recv_q + (LEN_W + 1)'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == LAST_IDX) ? '0 : rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) data_mem[wr_q] <= ram_data;
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed and randomised bench for ram_burst_reader against a deterministic memory model.
module tb_ram_burst_reader;

    localparam int AXI_WIDTH      = 128;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int LEN_W          = 16;
    localparam int FIFO_DEPTH     = 4;
    localparam int AW             = 28;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [AW-1:0]        cmd_addr = '0;
    logic [LEN_W-1:0]     cmd_len = '0;
    logic                 ram_ren;
    logic [AW-1:0]        ram_addr;
    logic [AXI_WIDTH-1:0] ram_data = '0;
    logic [AXI_WIDTH-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b0;
    logic                 m_axis_tlast;
    logic                 busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned tlast_count = 0;
    int unsigned ren_span = 0;
    int unsigned nb = 0;
    int unsigned tlast_base = 0;
    bit          post_rst_bad = 0;
    logic [AW-1:0] addr_log[$];

    ram_burst_reader #(
        .AXI_WIDTH      (AXI_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .LEN_W          (LEN_W),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .ram_ren       (ram_ren),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [AXI_WIDTH-1:0] word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {4'h0, a};
        return {x ^ 32'hA5A5_0000, ~x, x * 32'h9E37_79B1, x + 32'h0123_4567};
    endfunction

    // One-cycle-latency RAM
    always @(posedge clk) begin
        if (ram_ren) ram_data <= word(ram_addr);
    end

    task automatic check(input string tag, input logic [AXI_WIDTH-1:0] obs,
                         input logic [AXI_WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input logic [AW-1:0] addr, input int unsigned len,
                         input int unsigned stall, input bit rnd);
        int unsigned issued, beats, cyc, first_v, budget, ren_first, ren_last;
        bit stalled, order_bad, ready_bad;
        logic [AXI_WIDTH-1:0] held_d;
        logic held_l;
        issued = 0; beats = 0; first_v = 0; ren_first = 0; ren_last = 0;
        stalled = 0; order_bad = 0; ready_bad = 0; held_d = '0; held_l = 1'b0;
        budget = stall + 20 * (len + 1) + 100;
        addr_log.delete();
        check("cmd_ready_idle", {127'b0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = LEN_W'(len); m_axis_tready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (beats < len + 1 && cyc < budget) begin
            if (busy && cmd_ready) ready_bad = 1;
            if (ram_ren) begin
                if (issued == 0) ren_first = cyc;
                ren_last = cyc;
                addr_log.push_back(ram_addr);
                if (ram_addr !== AW'(addr + issued) || issued > len) order_bad = 1;
                issued++;
            end
            if (cyc <= stall) m_axis_tready = 1'b0;
            else m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("hold_valid", {127'b0, m_axis_tvalid}, 1);
                check("hold_data", m_axis_tdata, held_d);
                check("hold_last", {127'b0, m_axis_tlast}, {127'b0, held_l});
            end
            stalled = 0;
            if (m_axis_tvalid) begin
                if (first_v == 0) first_v = cyc;
                if (m_axis_tready) begin
                    check("beat_data", m_axis_tdata, word(AW'(addr + beats)));
                    check("beat_last", {127'b0, m_axis_tlast}, {127'b0, beats == len});
                    if (m_axis_tlast) tlast_count++;
                    beats++;
                end else begin
                    stalled = 1; held_d = m_axis_tdata; held_l = m_axis_tlast;
                end
            end
            if (stall > 0 && cyc == stall) check("stall_rens", issued, FIFO_DEPTH);
            @(negedge clk);
            cyc++;
        end
        check("beats", beats, len + 1);
        check("issued", issued, len + 1);
        check("first_valid", first_v, 3);
        check("addr_seq_ok", {127'b0, order_bad}, 0);
        for (int i = 0; i < 10 && busy; i++) begin
            if (cmd_ready) ready_bad = 1;
            @(negedge clk);
        end
        check("ready_while_busy", {127'b0, ready_bad}, 0);
        check("idle_after", {127'b0, busy}, 0);
        check("valid_after", {127'b0, m_axis_tvalid}, 0);
        ren_span = ren_last - ren_first;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {127'b0, cmd_ready}, 1);
        check("rst_ren", {127'b0, ram_ren}, 0);
        check("rst_addr", {100'b0, ram_addr}, 0);
        check("rst_tvalid", {127'b0, m_axis_tvalid}, 0);
        check("rst_tlast", {127'b0, m_axis_tlast}, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", {127'b0, busy}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Single beat
        burst(28'h10, 0, 0, 0);
        check("t1_addr0", {100'b0, addr_log[0]}, 128'h10);

        // Eight beats, full rate
        burst(28'h20, 7, 0, 0);
        check("t2_ren_span", ren_span, 7);
        check("t2_addr7", {100'b0, addr_log[7]}, 128'h27);

        // Backpressure for 20 cycles
        burst(28'h40, 15, 20, 0);

        // Address wrap
        burst(28'hFFF_FFFE, 3, 0, 0);
        check("t4_nren", addr_log.size(), 4);
        check("t4_a0", {100'b0, addr_log[0]}, 128'hFFF_FFFE);
        check("t4_a1", {100'b0, addr_log[1]}, 128'hFFF_FFFF);
        check("t4_a2", {100'b0, addr_log[2]}, 128'h0);
        check("t4_a3", {100'b0, addr_log[3]}, 128'h1);

        // Reset while beat 5 of a 10-beat burst is presented
        cmd_valid = 1'b1; cmd_addr = 28'h300; cmd_len = 16'd9; m_axis_tready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_axis_tvalid) begin
                if (nb == 5) break;
                nb++;
            end
            @(negedge clk);
        end
        check("t5_at_beat5", nb, 5);
        check("t5_head_data", m_axis_tdata, word(28'h305));
        #2 rstn = 1'b0;
        #1;
        check("t5_async_tvalid", {127'b0, m_axis_tvalid}, 0);
        check("t5_async_tdata", m_axis_tdata, 0);
        check("t5_async_tlast", {127'b0, m_axis_tlast}, 0);
        check("t5_async_ren", {127'b0, ram_ren}, 0);
        check("t5_async_addr", {100'b0, ram_addr}, 0);
        check("t5_async_busy", {127'b0, busy}, 0);
        check("t5_async_ready", {127'b0, cmd_ready}, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_axis_tvalid || !cmd_ready) post_rst_bad = 1;
        end
        check("t5_quiet_after", {127'b0, post_rst_bad}, 0);
        burst(28'h500, 4, 0, 0);

        // Random bursts
        tlast_base = tlast_count;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            burst(AW'($urandom), $urandom_range(0, 20), 0, 1);
        end
        check("t6_tlast_count", tlast_count - tlast_base, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
